// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and a
// helper that sizes the hold/pulse counter.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD_PERIPH = 2'd0,
        HOLD_CORE   = 2'd1,
        RUN         = 2'd2,
        ASSERT      = 2'd3
    } state_e;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR = 2'd0;
    localparam cause_t CAUSE_SW  = 2'd1;
    localparam cause_t CAUSE_DBG = 2'd2;
    localparam cause_t CAUSE_WDT = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Run-time reset requests in, staged resets and last-cause readout out.
// master = requester/consumer side, slave = the sequencer.
interface rst_seq_if;

    logic       i_sw_rst_req;
    logic       i_dbg_rst_req;
    logic       i_wdt_bite;
    logic       o_rst_periph;
    logic       o_rst_core;
    logic       o_ready;
    logic [1:0] o_rst_cause;

    modport master (
        output i_sw_rst_req, i_dbg_rst_req, i_wdt_bite,
        input  o_rst_periph, o_rst_core, o_ready, o_rst_cause
    );

    modport slave (
        input  i_sw_rst_req, i_dbg_rst_req, i_wdt_bite,
        output o_rst_periph, o_rst_core, o_ready, o_rst_cause
    );

endinterface

// File: rtl/rst_seq_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second
// clock edge after i_rst falls. Usable in any clock domain.
module rst_sync (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_rst_s
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= 1'b0;
            ff2_q <= ff1_q;
        end
    end

    assign o_rst_s = ff2_q;

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: peripherals released PERIPH_HOLD cycles after the
// synchronised release, core CORE_HOLD cycles later; run-time requests re-sequence.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int PERIPH_HOLD  = 16,
    parameter int CORE_HOLD    = 32,
    parameter int PULSE_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    rst_seq_if.slave    bus
);

    localparam int CNT_W = $clog2(max3(PERIPH_HOLD, CORE_HOLD, PULSE_CYCLES)) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_SAT     = '1;
    localparam cnt_t PERIPH_LAST = cnt_t'(PERIPH_HOLD - 1);
    localparam cnt_t CORE_LAST   = cnt_t'(CORE_HOLD - 1);
    localparam cnt_t PULSE_LAST  = cnt_t'(PULSE_CYCLES - 1);

    logic   rst_s;
    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    cause_t cause_q, cause_d;
    logic   periph_q, periph_d;
    logic   core_q, core_d;
    logic   ready_q, ready_d;

    // rst_s asserts with i_rst, so every flop below is forced asynchronously.
    rst_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_rst_s (rst_s)
    );

    always_ff @(posedge i_clk or posedge rst_s) begin
        if (rst_s) begin
            state_q  <= HOLD_PERIPH;
            cnt_q    <= '0;
            cause_q  <= CAUSE_POR;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + cnt_t'(1);

        case (state_q)
            HOLD_PERIPH: begin
                if (cnt_q == PERIPH_LAST) begin
                    state_d = HOLD_CORE;
                    cnt_d   = '0;
                end
            end
            HOLD_CORE: begin
                if (cnt_q == CORE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                // Highest-priority request wins; requests in other states are dropped.
                if (bus.i_wdt_bite) begin
                    state_d = ASSERT;
                    cause_d = CAUSE_WDT;
                end else if (bus.i_dbg_rst_req) begin
                    state_d = ASSERT;
                    cause_d = CAUSE_DBG;
                end else if (bus.i_sw_rst_req) begin
                    state_d = ASSERT;
                    cause_d = CAUSE_SW;
                end
            end
            ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = HOLD_PERIPH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = HOLD_PERIPH;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge.
        periph_d = (state_d == HOLD_PERIPH) || (state_d == ASSERT);
        core_d   = (state_d != RUN);
        ready_d  = (state_d == RUN);
    end

    assign bus.o_rst_periph = periph_q;
    assign bus.o_rst_core   = core_q;
    assign bus.o_ready      = ready_q;
    assign bus.o_rst_cause  = cause_q;

endmodule
